// File: rtl/pulse_conditioner_if.sv
// rtl/pulse_conditioner_if.sv - bundle of pulse front-end inputs, controls and outputs
//
// Purpose: groups the per-channel pulse inputs, quasi-static controls,
//          counter strobes and the conditioned outputs of pulse_conditioner.
// Modports:
//   master - drives pulse_in, invert, edge_mode, min_width, holdoff,
//            count_latch, count_clear; observes pulse_out, level_out,
//            counts, overflow
//   slave  - the conditioner itself (mirror of master)
interface pulse_conditioner_if #(
   parameter int NUM_INPUTS    = 12,
   parameter int FILTER_WIDTH  = 4,
   parameter int HOLDOFF_WIDTH = 8,
   parameter int COUNT_WIDTH   = 16
) ();
   logic [NUM_INPUTS-1:0]             pulse_in;
   logic [NUM_INPUTS-1:0]             invert;
   logic [1:0]                        edge_mode;
   logic [FILTER_WIDTH-1:0]           min_width;
   logic [HOLDOFF_WIDTH-1:0]          holdoff;
   logic                              count_latch;
   logic                              count_clear;
   logic [NUM_INPUTS-1:0]             pulse_out;
   logic [NUM_INPUTS-1:0]             level_out;
   logic [NUM_INPUTS*COUNT_WIDTH-1:0] counts;
   logic [NUM_INPUTS-1:0]             overflow;

   modport master (
      output pulse_in, invert, edge_mode, min_width, holdoff, count_latch, count_clear,
      input  pulse_out, level_out, counts, overflow
   );

   modport slave (
      input  pulse_in, invert, edge_mode, min_width, holdoff, count_latch, count_clear,
      output pulse_out, level_out, counts, overflow
   );
endinterface

// File: rtl/pulse_conditioner.sv
// rtl/pulse_conditioner.sv - per-channel sync, glitch filter, edge detect, holdoff and counters
//
// Purpose: conditions NUM_INPUTS asynchronous pulse lines into single-cycle
//          pulse_out strobes plus filtered levels, with optional per-channel
//          pulse counters.
// Optional feature macro: PULSE_COUNTERS_EN (defined -> counters, counts and
//          overflow implemented; undefined -> counts/overflow tied to 0 and
//          count_latch/count_clear ignored).
// Ports:
//   clk     - single rising-edge clock
//   reset_n - asynchronous active-low reset
//   bus     - pulse_conditioner_if.slave: pulse_in, invert, edge_mode,
//             min_width, holdoff, count_latch, count_clear in;
//             pulse_out, level_out, counts, overflow out
module pulse_conditioner #(
   parameter int NUM_INPUTS    = 12,
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_WIDTH  = 4,
   parameter int HOLDOFF_WIDTH = 8,
   parameter int COUNT_WIDTH   = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   pulse_conditioner_if.slave   bus
);

   logic [NUM_INPUTS-1:0]                    r_sync [SYNC_STAGES];
   logic [NUM_INPUTS-1:0]                    r_level;
   logic [NUM_INPUTS-1:0]                    r_level_d;
   logic [NUM_INPUTS-1:0]                    r_pulse;
   logic [NUM_INPUTS-1:0][FILTER_WIDTH-1:0]  r_fc;
   logic [NUM_INPUTS-1:0][HOLDOFF_WIDTH-1:0] r_ho;

   logic [NUM_INPUTS-1:0] w_lvl;
   logic [NUM_INPUTS-1:0] w_rise;
   logic [NUM_INPUTS-1:0] w_fall;
   logic [NUM_INPUTS-1:0] w_edge;
   logic [NUM_INPUTS-1:0] w_accept;

   // Polarity is applied after the synchroniser so toggling invert never
   // reaches a metastable flop.
   assign w_lvl  = r_sync[SYNC_STAGES-1] ^ bus.invert;
   assign w_rise = r_level & ~r_level_d;
   assign w_fall = ~r_level & r_level_d;

   always_comb begin
      w_edge = '0;
      case (bus.edge_mode)
         2'b01:   w_edge = w_rise;
         2'b10:   w_edge = w_fall;
         2'b11:   w_edge = w_rise | w_fall;
         default: w_edge = '0;
      endcase
   end

   // An edge is taken only once the dead-time counter has drained to zero.
   always_comb begin
      w_accept = '0;
      for (int c = 0; c < NUM_INPUTS; c++) begin
         w_accept[c] = w_edge[c] & (r_ho[c] == '0);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            r_sync[s] <= '0;
         end
         r_level   <= '0;
         r_level_d <= '0;
         r_pulse   <= '0;
         r_fc      <= '0;
         r_ho      <= '0;
      end else begin
         r_sync[0] <= bus.pulse_in;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            r_sync[s] <= r_sync[s-1];
         end
         r_level_d <= r_level;
         r_pulse   <= w_accept;
         for (int c = 0; c < NUM_INPUTS; c++) begin
            // >= rather than == keeps the filter from wrapping if min_width
            // is lowered while a count is in progress.
            if (w_lvl[c] != r_level[c]) begin
               if (r_fc[c] >= bus.min_width) begin
                  r_level[c] <= ~r_level[c];
                  r_fc[c]    <= '0;
               end else begin
                  r_fc[c] <= r_fc[c] + 1'b1;
               end
            end else begin
               r_fc[c] <= '0;
            end

            if (w_accept[c]) begin
               r_ho[c] <= bus.holdoff;
            end else if (r_ho[c] != '0) begin
               r_ho[c] <= r_ho[c] - 1'b1;
            end
         end
      end
   end

   assign bus.pulse_out = r_pulse;
   assign bus.level_out = r_level;

`ifdef PULSE_COUNTERS_EN
   logic [NUM_INPUTS-1:0][COUNT_WIDTH-1:0] r_cnt;
   logic [NUM_INPUTS-1:0]                  r_ovf_live;
   logic [NUM_INPUTS-1:0][COUNT_WIDTH-1:0] r_counts;
   logic [NUM_INPUTS-1:0]                  r_ovf;
   logic [NUM_INPUTS-1:0][COUNT_WIDTH-1:0] w_cnt_next;
   logic [NUM_INPUTS-1:0]                  w_ovf_next;

   // Live value including this cycle's pulse, so a latch coincident with a
   // pulse still captures it. Overflow marks a pulse lost at saturation.
   always_comb begin
      w_cnt_next = r_cnt;
      w_ovf_next = r_ovf_live;
      for (int c = 0; c < NUM_INPUTS; c++) begin
         if (r_pulse[c]) begin
            if (&r_cnt[c]) begin
               w_ovf_next[c] = 1'b1;
            end else begin
               w_cnt_next[c] = r_cnt[c] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt      <= '0;
         r_ovf_live <= '0;
         r_counts   <= '0;
         r_ovf      <= '0;
      end else if (bus.count_clear) begin
         r_cnt      <= '0;
         r_ovf_live <= '0;
         r_counts   <= '0;
         r_ovf      <= '0;
      end else if (bus.count_latch) begin
         r_counts   <= w_cnt_next;
         r_ovf      <= w_ovf_next;
         r_cnt      <= '0;
         r_ovf_live <= '0;
      end else begin
         r_cnt      <= w_cnt_next;
         r_ovf_live <= w_ovf_next;
      end
   end

   assign bus.counts   = r_counts;
   assign bus.overflow = r_ovf;
`else
   logic w_unused_ctl;
   assign w_unused_ctl = bus.count_latch ^ bus.count_clear;
   assign bus.counts   = '0;
   assign bus.overflow = '0;
`endif

endmodule

// File: doc/pulse_conditioner.md
# pulse_conditioner

Parametrised per-channel pulse front end for the interferometer correlator; it replaces the fixed one-cycle delay and falling-edge detector that feeds `main`. Each of `NUM_INPUTS` photon/pulse lines is synchronised, glitch-filtered, edge-detected with a selectable edge mode and dead-time holdoff, and counted per channel. It produces single-cycle `pulse_out` strobes for the correlator array and latched per-channel counts for the integration readout.

## Interface
- `NUM_INPUTS`, 12, number of channels
- `SYNC_STAGES`, 2, synchroniser flops per channel (min 2)
- `FILTER_WIDTH`, 4, width of glitch-filter counter and `min_width`
- `HOLDOFF_WIDTH`, 8, width of dead-time counter and `holdoff`
- `COUNT_WIDTH`, 16, width of each per-channel pulse counter

- `clk` in 1: the single clock (PLL output), all logic rising-edge
- `reset_n` in 1: asynchronous, active-low reset
- `pulse_in` in NUM_INPUTS: raw asynchronous inputs
- `invert` in NUM_INPUTS: per-channel polarity; 1 inverts the channel after synchronisation
- `edge_mode` in 2: 00 disabled, 01 rising, 10 falling, 11 both
- `min_width` in FILTER_WIDTH: cycles of stability required beyond one
- `holdoff` in HOLDOFF_WIDTH: dead-time cycles after each accepted pulse; 0 = none
- `count_latch` in 1: strobe; snapshot and restart counters
- `count_clear` in 1: strobe; zero live and snapshot counters
- `pulse_out` out NUM_INPUTS: one-cycle strobe per accepted edge
- `level_out` out NUM_INPUTS: filtered, polarity-corrected level
- `counts` out NUM_INPUTS*COUNT_WIDTH: snapshot counts, channel i at bits [i*COUNT_WIDTH +: COUNT_WIDTH]
- `overflow` out NUM_INPUTS: sticky saturation flag per snapshot

## Operation
- Per channel: sync chain -> XOR `invert` -> filter -> edge detect -> holdoff gate -> `pulse_out` register -> counter.
- Filter: counter `fc` counts consecutive cycles where the synced level differs from `level_out`; when difference persists and `fc == min_width`, `level_out` toggles and `fc` clears; any cycle with equal levels clears `fc`.
- Edge detect compares `level_out` with its previous value; qualified by `edge_mode`. Mode 00 forces no pulses; filter still runs.
- Holdoff: accepted pulse loads `ho = holdoff`; while `ho != 0` detected edges are dropped and `ho` decrements. An edge in the cycle `ho` reaches 0 is accepted.
- Counter: live counter increments on each `pulse_out`; saturates at all-ones and sets live overflow.
- `count_latch`: `counts`/`overflow` take live values (including a pulse in that same cycle); live counter restarts at 0, live overflow cleared.
- `count_clear` has priority over `count_latch`; both zero live and snapshot state. A pulse coincident with clear is discarded.
- Control inputs (`invert`, `edge_mode`, `min_width`, `holdoff`) are quasi-static; changes take effect the next cycle, no glitch protection. Inverting a channel produces one edge at `level_out`.

## Timing
- Reset: all sync flops, `level_out`, `fc`, `ho`, `pulse_out`, counters, `counts`, `overflow` = 0.
- Input high at reset release yields a rising edge after normal latency.
- Latency: new level first sampled at edge 1; `level_out` changes at edge SYNC_STAGES+1+min_width; `pulse_out` high for one cycle after edge SYNC_STAGES+2+min_width.
- Pulses narrower than min_width+1 cycles (after sync) produce no output.
- Max pulse rate per channel: one per holdoff+1 cycles.
- `counts` updates one edge after the `count_latch` cycle.
- Reset mid-operation clears everything immediately, asynchronously.

## Configuration
- `PULSE_COUNTERS_EN`: defined -> counters, `counts`, `overflow` implemented as above. Undefined -> no counter logic; `counts` and `overflow` tie to 0; `count_latch`/`count_clear` ignored; pulse path unchanged.

## Test plan
- SYNC_STAGES=2, min_width=0, mode 01: channel 0 low->high held 10 cycles -> single `pulse_out[0]` after edge 4, `level_out[0]`=1.
- min_width=3: 3-cycle high glitch -> no pulse, `level_out` stays 0; 4-cycle high -> pulse after edge 7.
- mode 11, holdoff=5: edges 3 cycles apart -> second edge dropped; edges 6 cycles apart -> both pulse.
- 5 pulses then `count_latch` coincident with 6th pulse -> `counts[0]`=6, next latch with no pulses -> 0.
- COUNT_WIDTH=4, 20 pulses then latch -> `counts`=15, `overflow`=1; `count_clear` with latch -> both 0.
- Assert `reset_n` low mid-pulse -> all outputs 0 immediately; undefined `PULSE_COUNTERS_EN` -> `counts` stays 0 throughout.
